// File: rtl/data_mem_master.sv
// Data memory initiator: maps byte-addressed MEM-stage loads/stores onto a
// word-wide memory with one-cycle registered reads, stalling until complete.
module data_mem_master #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned WORD_SIZE    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Req,
  input  logic                    ReqWrite,
  input  logic [1:0]              ReqSize,
  input  logic                    ReqUnsigned,
  input  logic [ADDRESS_SIZE-1:0] ReqAddr,
  input  logic [WORD_SIZE-1:0]    ReqWData,
  output logic                    Stall,
  output logic                    RespValid,
  output logic [WORD_SIZE-1:0]    LoadData,
  output logic                    AddrErr,
  output logic [ADDRESS_SIZE-1:0] MemAddress,
  output logic [WORD_SIZE-1:0]    MemWriteData,
  output logic                    MemRead,
  output logic                    MemWrite,
  input  logic [WORD_SIZE-1:0]    MemReadData
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_write, w_write_nxt;
  logic [1:0]              r_size, w_size_nxt;
  logic                    r_unsigned, w_unsigned_nxt;
  logic [1:0]              r_lane, w_lane_nxt;
  logic [15:0]             r_wdata_lo, w_wdata_lo_nxt;
  logic                    r_mem_read, w_mem_read_nxt;
  logic                    r_mem_write, w_mem_write_nxt;
  logic                    r_resp_valid, w_resp_valid_nxt;
  logic                    r_addr_err, w_addr_err_nxt;
  logic [WORD_SIZE-1:0]    r_load_data, w_load_data_nxt;
  logic [WORD_SIZE-1:0]    r_mem_wdata, w_mem_wdata_nxt;
  logic [ADDRESS_SIZE-1:0] r_mem_address, w_mem_address_nxt;

  logic                    w_req_err;
  logic                    w_req_word_store;
  logic [7:0]              w_lane_byte;
  logic [15:0]             w_lane_half;
  logic [WORD_SIZE-1:0]    w_load_ext;
  logic [WORD_SIZE-1:0]    w_merged;

  assign w_req_err = (ReqSize == SZ_RSVD) ||
                     ((ReqSize == SZ_HALF) && ReqAddr[0]) ||
                     ((ReqSize == SZ_WORD) && (ReqAddr[1:0] != 2'b00));
  assign w_req_word_store = ReqWrite && (ReqSize == SZ_WORD);

  // Lane extraction/extension for loads and byte-lane merge for partial stores
  always_comb begin
    w_lane_byte = MemReadData[{r_lane, 3'b000} +: 8];
    w_lane_half = MemReadData[{r_lane[1], 4'b0000} +: 16];
    case (r_size)
      SZ_BYTE: w_load_ext = {{(WORD_SIZE-8){~r_unsigned & w_lane_byte[7]}}, w_lane_byte};
      SZ_HALF: w_load_ext = {{(WORD_SIZE-16){~r_unsigned & w_lane_half[15]}}, w_lane_half};
      default: w_load_ext = MemReadData;
    endcase
    w_merged = MemReadData;
    if (r_size == SZ_BYTE) begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata_lo[7:0];
    end else begin
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata_lo;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    w_state_nxt       = r_state;
    w_write_nxt       = r_write;
    w_size_nxt        = r_size;
    w_unsigned_nxt    = r_unsigned;
    w_lane_nxt        = r_lane;
    w_wdata_lo_nxt    = r_wdata_lo;
    w_mem_read_nxt    = 1'b0;
    w_mem_write_nxt   = 1'b0;
    w_resp_valid_nxt  = 1'b0;
    w_addr_err_nxt    = r_addr_err;
    w_load_data_nxt   = r_load_data;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_mem_address_nxt = r_mem_address;
    case (r_state)
      IDLE: begin
        if (Req) begin
          w_write_nxt       = ReqWrite;
          w_size_nxt        = ReqSize;
          w_unsigned_nxt    = ReqUnsigned;
          w_lane_nxt        = ReqAddr[1:0];
          w_wdata_lo_nxt    = ReqWData[15:0];
          w_mem_address_nxt = {2'b00, ReqAddr[ADDRESS_SIZE-1:2]};
          if (w_req_err) begin
            w_state_nxt      = DONE;
            w_resp_valid_nxt = 1'b1;
            w_addr_err_nxt   = 1'b1;
            w_load_data_nxt  = '0;
          end else if (w_req_word_store) begin
            w_state_nxt     = WR;
            w_mem_write_nxt = 1'b1;
            w_mem_wdata_nxt = ReqWData;
          end else begin
            w_state_nxt    = RD;
            w_mem_read_nxt = 1'b1;
          end
        end
      end
      RD: w_state_nxt = CAP;
      CAP: begin
        if (r_write) begin
          w_state_nxt     = WR;
          w_mem_write_nxt = 1'b1;
          w_mem_wdata_nxt = w_merged;
        end else begin
          w_state_nxt      = DONE;
          w_resp_valid_nxt = 1'b1;
          w_addr_err_nxt   = 1'b0;
          w_load_data_nxt  = w_load_ext;
        end
      end
      WR: begin
        w_state_nxt      = DONE;
        w_resp_valid_nxt = 1'b1;
        w_addr_err_nxt   = 1'b0;
        w_load_data_nxt  = '0;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_write       <= 1'b0;
      r_size        <= 2'b00;
      r_unsigned    <= 1'b0;
      r_lane        <= 2'b00;
      r_wdata_lo    <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_addr_err    <= 1'b0;
      r_load_data   <= '0;
      r_mem_wdata   <= '0;
      r_mem_address <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_write       <= w_write_nxt;
      r_size        <= w_size_nxt;
      r_unsigned    <= w_unsigned_nxt;
      r_lane        <= w_lane_nxt;
      r_wdata_lo    <= w_wdata_lo_nxt;
      r_mem_read    <= w_mem_read_nxt;
      r_mem_write   <= w_mem_write_nxt;
      r_resp_valid  <= w_resp_valid_nxt;
      r_addr_err    <= w_addr_err_nxt;
      r_load_data   <= w_load_data_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_mem_address <= w_mem_address_nxt;
    end
  end

  assign Stall        = Req & ~r_resp_valid;
  assign RespValid    = r_resp_valid;
  assign LoadData     = r_load_data;
  assign AddrErr      = r_addr_err;
  assign MemAddress   = r_mem_address;
  assign MemWriteData = r_mem_wdata;
  assign MemRead      = r_mem_read;
  assign MemWrite     = r_mem_write;

endmodule

// File: doc/data_mem_master.md
Name: data_mem_master

Overview:
- Initiator side of the word-addressed data memory interface (Address/WriteData/MemRead/MemWrite/ReadData, one-cycle registered read).
- Sits between the pipeline MEM stage and the data memory.
- Turns byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word accesses: read-modify-write for partial stores, lane extract plus sign/zero extension for loads.
- Stalls the pipeline until each access completes.

Parameters:
- ADDRESS_SIZE, 32, width of byte address and of memory word-index bus.
- WORD_SIZE, 32, data width; fixed at 32 (4 byte lanes), other values unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- Req  in  1  MEM stage access request; held stable with all Req* fields until RespValid
- ReqWrite  in  1  1=store, 0=load
- ReqSize  in  2  00 byte, 01 half, 10 word, 11 reserved
- ReqUnsigned  in  1  loads: 1 zero-extend, 0 sign-extend
- ReqAddr  in  ADDRESS_SIZE  byte address
- ReqWData  in  WORD_SIZE  store data, right-aligned
- Stall  out  1  Req & ~RespValid (combinational)
- RespValid  out  1  one-cycle completion pulse
- LoadData  out  WORD_SIZE  extended load result, valid with RespValid
- AddrErr  out  1  misaligned/reserved-size flag, valid with RespValid
- MemAddress  out  ADDRESS_SIZE  word index = {2'b00, latched ReqAddr[ADDRESS_SIZE-1:2]}
- MemWriteData  out  WORD_SIZE  word to write
- MemRead  out  1  read strobe
- MemWrite  out  1  write strobe
- MemReadData  in  WORD_SIZE  memory data, valid the cycle after MemRead was high at a clock edge

Behaviour:
- Registered outputs: MemAddress, MemWriteData, MemRead, MemWrite, RespValid, LoadData, AddrErr.
- Reset (rst high at an edge): state IDLE, all registered outputs 0, latched request cleared.
- Reset takes priority over everything. A reset during RD/CAP/WR aborts the access. No MemWrite is asserted in the cycle after the reset edge.
- MemRead and MemWrite are never both 1 in the same cycle.
- Request fields are latched only in IDLE when Req=1.
- States and transitions:
  - IDLE: Req=0 stays IDLE. Req=1 with error goes to DONE with AddrErr=1. Load or partial store goes to RD. Word store goes to WR.
  - RD: MemRead=1 for exactly one cycle. Goes to CAP.
  - CAP: samples MemReadData. Load: extract the lane into LoadData, then DONE. Partial store: merge store bytes into the sampled word in MemWriteData, then WR.
  - WR: MemWrite=1 for exactly one cycle, MemWriteData = merged word or ReqWData. Goes to DONE.
  - DONE: RespValid=1 for one cycle, then IDLE. A new Req is first sampled in the following IDLE cycle.
- Error conditions: half with ReqAddr[0]=1, word with ReqAddr[1:0]!=0, or ReqSize=11. No memory strobe is asserted. LoadData=0 and AddrErr=1 in DONE.
- Lanes are little-endian: byte k occupies bits [8k+7:8k], k=ReqAddr[1:0]. Half uses bits [16h+15:16h], h=ReqAddr[1].
- Loads: selected lane extended to 32 bits per ReqUnsigned. Word loads pass through unchanged.
- Partial stores: only the addressed lane changes; all other bytes keep the read value.
- Latency from the first cycle Req is seen in IDLE (cycle 0) to the RespValid cycle:
  - word store: 2
  - any load: 3
  - partial store: 4
  - error: 1
- AddrErr and LoadData hold their values until the next DONE or reset. RespValid returns to 0 after its pulse.
- Back-to-back requests: minimum one IDLE cycle between a DONE and the next RD/WR.

Test Plan:
- Reset, then sw ReqAddr=0x0000_0010 data 0xDEADBEEF → MemWrite=1 at cycle 1 with MemAddress=4 and MemWriteData=0xDEADBEEF; RespValid at cycle 2; Stall high during cycles 0–1.
- lb ReqAddr=0x11, mem[4]=0xDEADBEEF → MemRead at cycle 1; LoadData=0xFFFFFFBE with RespValid at cycle 3. lbu at the same address → 0x000000BE. lh at 0x12 → 0xFFFFDEAD.
- sb ReqAddr=0x13 data 0x0000_0055, mem[4]=0xDEADBEEF → RD, CAP, then WR with MemWriteData=0x55ADBEEF at cycle 3; RespValid at cycle 4; mem[4]=0x55ADBEEF afterwards.
- lw ReqAddr=0x6 → RespValid at cycle 1 with AddrErr=1 and LoadData=0. MemRead and MemWrite stay 0 throughout. ReqSize=11 gives the same response.
- sh ReqAddr=0x20 with rst asserted in the CAP cycle → next cycle is IDLE with MemWrite=0 and RespValid=0; mem[8] unchanged; a following lw 0x20 completes normally.
- Back-to-back lw 0x10 then sw 0x14 with Req held → exactly one IDLE gap; never MemRead and MemWrite both 1; Stall low only in the RespValid cycles.
